// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: accepts a 128-bit state, substitutes LANES bytes per
// clock through the FIPS-197 forward S-box, then offers the result downstream.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

    // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
    always_comb begin
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NCH = 16 / LANES;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CHB = 8 * LANES;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    logic [1:0]     state;
    logic [127:0]   st;
    logic [CW-1:0]  cnt;
    logic [CHB-1:0] chunk_in;
    logic [CHB-1:0] chunk_out;

    always_comb begin
        chunk_in = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (cnt == CW'(c)) chunk_in = st[c*CHB +: CHB];
        end
    end

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            aes_sbox u_sbox (
                .a(chunk_in[8*l +: 8]),
                .s(chunk_out[8*l +: 8])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            st    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st    <= in_state;
                        cnt   <= '0;
                        state <= SUB;
                    end
                end
                SUB: begin
                    for (int unsigned c = 0; c < NCH; c++) begin
                        if (cnt == CW'(c)) st[c*CHB +: CHB] <= chunk_out;
                    end
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SUB) || (state == DONE);
    assign out_state = st;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: five instances (LANES 1..16) share stimulus; the
// LANES=4 instance is additionally tracked by a queue-based scoreboard.

module tb_sub_bytes_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_state;
    logic [4:0]   in_ready_v;
    logic [4:0]   out_valid_v;
    logic [4:0]   busy_v;
    logic [127:0] out_state_v [5];

    generate
        for (genvar g = 0; g < 5; g++) begin : g_dut
            sub_bytes_seq #(.LANES(1 << g)) u_dut (
                .clk(clk),
                .rst(rst),
                .in_valid(in_valid),
                .in_ready(in_ready_v[g]),
                .in_state(in_state),
                .out_valid(out_valid_v[g]),
                .out_ready(out_ready),
                .out_state(out_state_v[g]),
                .busy(busy_v[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference S-box built from log/antilog tables over generator 0x03.
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic build_sbox();
        logic [7:0] exp_t [256];
        int         log_t [256];
        logic [7:0] inv, r;
        logic [7:0] c;
        c = 8'h63;
        exp_t[0] = 8'h01;
        for (int i = 1; i < 256; i++) exp_t[i] = xtime(exp_t[i-1]) ^ exp_t[i-1];
        for (int i = 0; i < 256; i++) log_t[i] = 0;
        for (int i = 0; i < 255; i++) log_t[exp_t[i]] = i;
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
            for (int b = 0; b < 8; b++)
                r[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            sbox_m[x] = r;
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_m[s[8*k +: 8]];
        return r;
    endfunction

    // Scoreboard for the LANES=4 instance.
    logic [127:0] exp_q [$];
    int           out_cyc_q [$];

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready_v[2]) exp_q.push_back(model(in_state));
            if (out_valid_v[2] && out_ready) begin
                out_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL sb_underflow: got output %h, expected none", out_state_v[2]);
                end else begin
                    check("sb_data", out_state_v[2], exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (&in_ready_v) return;
        end
        checks++;
        fails++;
        $display("FAIL idle_timeout: got in_ready %b, expected 11111", in_ready_v);
    endtask

    // Drives one block into all instances and checks data and latency of each.
    task automatic run_all(input logic [127:0] din, input logic [127:0] dout, input string tag);
        bit seen [5];
        for (int g = 0; g < 5; g++) seen[g] = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_state  = din;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            for (int g = 0; g < 5; g++) begin
                if (!seen[g] && out_valid_v[g]) begin
                    seen[g] = 1'b1;
                    check($sformatf("%s_data_L%0d", tag, 1 << g), out_state_v[g], dout);
                    check($sformatf("%s_lat_L%0d", tag, 1 << g), 128'(k - 1), 128'(16 >> g));
                end
            end
        end
        for (int g = 0; g < 5; g++) begin
            if (!seen[g]) begin
                checks++;
                fails++;
                $display("FAIL %s_timeout_L%0d: got no out_valid, expected one", tag, 1 << g);
            end
        end
    endtask

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
        string        tag;
    } vec_t;

    localparam logic [127:0] APPB_IN  = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
    localparam logic [127:0] APPB_OUT = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;

    initial begin
        vec_t         vecs [3];
        logic [127:0] held;
        int           nv;

        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_state  = '0;
        rst       = 1'b1;
        build_sbox();

        vecs[0] = '{APPB_IN, APPB_OUT, "appb"};
        vecs[1] = '{{16{8'h00}}, {16{8'h63}}, "zero"};
        vecs[2] = '{{16{8'h53}}, {16{8'hed}}, "x53"};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready_v), 128'(5'b11111));
        check("rst_out_valid", 128'(out_valid_v), 128'(0));
        check("rst_busy", 128'(busy_v), 128'(0));
        check("rst_out_state", out_state_v[2], 128'(0));

        for (int i = 0; i < 3; i++) run_all(vecs[i].din, vecs[i].dout, vecs[i].tag);

        // Backpressure: hold DONE, push a conflicting state at the input.
        wait_idle();
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_state  = APPB_IN;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !out_valid_v[2]; k++) @(negedge clk);
        check("bp_reach_done", 128'(out_valid_v[2]), 128'(1));
        check("bp_data", out_state_v[2], APPB_OUT);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_state = {16{8'ha5}};
        nv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!out_valid_v[2] || in_ready_v[2] || out_state_v[2] !== APPB_OUT) nv++;
        end
        check("bp_hold_violations", 128'(nv), 128'(0));
        in_valid  = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_release_in_ready", 128'(in_ready_v[2]), 128'(1));
        check("bp_release_out_valid", 128'(out_valid_v[2]), 128'(0));

        // Back-to-back stream with out_ready held high.
        wait_idle();
        out_cyc_q.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            in_state = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (in_ready_v[2]) break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        check("stream_outputs", 128'(out_cyc_q.size()), 128'(8));
        for (int i = 1; i < out_cyc_q.size(); i++)
            check($sformatf("stream_spacing_%0d", i), 128'(out_cyc_q[i] - out_cyc_q[i-1]), 128'(6));

        // Reset two cycles into SUB.
        wait_idle();
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_state = APPB_IN;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 128'(out_valid_v[2]), 128'(0));
        check("mid_rst_in_ready", 128'(in_ready_v[2]), 128'(1));
        check("mid_rst_out_state", out_state_v[2], 128'(0));
        nv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid_v[2]) nv++;
        end
        check("mid_rst_stale_valid", 128'(nv), 128'(0));
        run_all(APPB_IN, APPB_OUT, "post_rst");

        wait_idle();
        check("sb_drained", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
